// File: rtl/nn_pkg.sv
// Shared definitions for the dense-layer engine: state encoding, default
// fixed-point widths and a constant clog2 helper for address widths.
package nn_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_MAC   = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_ACC_W     = 28;
    localparam int DEF_FRAC_BITS = 7;

    function automatic int nn_clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

    // A depth of one still needs a one-bit address port.
    function automatic int nn_addr_w(input int n);
        int r;
        r = nn_clog2(n);
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dense_layer_engine_if.sv
// Go/Done handshake plus activation/weight/bias read ports and result write
// port of the dense-layer engine; master = engine side, slave = environment.
interface dense_layer_engine_if #(
    parameter int N_IN   = 784,
    parameter int N_OUT  = 16,
    parameter int DATA_W = nn_pkg::DEF_DATA_W
) ();

    localparam int IN_AW  = nn_pkg::nn_addr_w(N_IN);
    localparam int W_AW   = nn_pkg::nn_addr_w(N_IN * N_OUT);
    localparam int OUT_AW = nn_pkg::nn_addr_w(N_OUT);

    logic              go;
    logic              busy;
    logic              done;
    logic [IN_AW-1:0]  in_addr;
    logic [DATA_W-1:0] in_data;
    logic [W_AW-1:0]   w_addr;
    logic [DATA_W-1:0] w_data;
    logic [OUT_AW-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic [OUT_AW-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic              out_we;

    modport master (
        input  go,
        output busy,
        output done,
        output in_addr,
        input  in_data,
        output w_addr,
        input  w_data,
        output b_addr,
        input  b_data,
        output out_addr,
        output out_data,
        output out_we
    );

    modport slave (
        output go,
        input  busy,
        input  done,
        input  in_addr,
        output in_data,
        input  w_addr,
        output w_data,
        input  b_addr,
        output b_data,
        input  out_addr,
        input  out_data,
        input  out_we
    );

endinterface

// File: rtl/nn_sat_act.sv
// Combinational output stage: arithmetic shift by FRAC_BITS, clamp to the
// signed DATA_W range, then ReLU when DENSE_LAYER_RELU_EN is defined.
module nn_sat_act
    import nn_pkg::*;
#(
    parameter int ACC_W     = DEF_ACC_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int FRAC_BITS = DEF_FRAC_BITS
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] result
);

    localparam logic signed [ACC_W-1:0] POS_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] NEG_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [ACC_W-1:0]  shifted_s;
    logic signed [DATA_W-1:0] sat_s;

    // Floor-shift and clamp, then apply the build-selected activation.
    always_comb begin
        shifted_s = acc >>> FRAC_BITS;
        if (shifted_s > POS_MAX) begin
            sat_s = OUT_MAX;
        end else if (shifted_s < NEG_MIN) begin
            sat_s = OUT_MIN;
        end else begin
            sat_s = shifted_s[DATA_W-1:0];
        end
`ifdef DENSE_LAYER_RELU_EN
        if (sat_s[DATA_W-1]) begin
            result = {DATA_W{1'b0}};
        end else begin
            result = sat_s;
        end
`else
        result = sat_s;
`endif
    end

endmodule

// File: rtl/dense_layer_engine.sv
// One go pulse computes a full fully-connected layer from 1-cycle-latency
// memories. ReLU output stage selected by DENSE_LAYER_RELU_EN (default: linear).
module dense_layer_engine
    import nn_pkg::*;
#(
    parameter int N_IN      = 784,
    parameter int N_OUT     = 16,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int FRAC_BITS = DEF_FRAC_BITS
) (
    input  logic clock,
    input  logic reset,
    dense_layer_engine_if.master bus
);

    localparam int IA = nn_addr_w(N_IN);
    localparam int WA = nn_addr_w(N_IN * N_OUT);
    localparam int OA = nn_addr_w(N_OUT);
    localparam logic [IA-1:0] K_LAST    = IA'(N_IN - 1);
    localparam logic [OA-1:0] J_LAST    = OA'(N_OUT - 1);
    localparam logic [WA-1:0] BASE_STEP = WA'(N_IN);
    localparam logic          MULTI_IN  = (N_IN > 1);

    logic [2:0]               state_r;
    logic [2:0]               state_next_s;
    logic [OA-1:0]            j_r;
    logic [IA-1:0]            k_r;
    logic [WA-1:0]            base_r;
    logic signed [ACC_W-1:0]  acc_r;
    logic [IA-1:0]            in_addr_r;
    logic [WA-1:0]            w_addr_r;
    logic [OA-1:0]            b_addr_r;
    logic [OA-1:0]            out_addr_r;
    logic [DATA_W-1:0]        out_data_r;
    logic                     out_we_r;
    logic                     busy_r;
    logic                     done_r;

    logic signed [2*DATA_W-1:0] in_ext_s;
    logic signed [2*DATA_W-1:0] w_ext_s;
    logic signed [2*DATA_W-1:0] product_s;
    logic signed [ACC_W-1:0]    prod_ext_s;
    logic signed [ACC_W-1:0]    bias_shift_s;
    logic signed [ACC_W-1:0]    acc_base_s;
    logic signed [ACC_W-1:0]    mac_sum_s;
    logic signed [DATA_W-1:0]   act_s;
    logic                       k_last_s;
    logic                       j_last_s;
    logic                       issue_s;

    assign k_last_s = (k_r == K_LAST);
    assign j_last_s = (j_r == J_LAST);
    assign issue_s  = ((32'(k_r) + 32'd2) < 32'(N_IN));

    // Signed product and accumulator update; k=0 seeds with the scaled bias.
    always_comb begin
        in_ext_s     = {{DATA_W{bus.in_data[DATA_W-1]}}, bus.in_data};
        w_ext_s      = {{DATA_W{bus.w_data[DATA_W-1]}}, bus.w_data};
        product_s    = in_ext_s * w_ext_s;
        prod_ext_s   = {{(ACC_W-2*DATA_W){product_s[2*DATA_W-1]}}, product_s};
        bias_shift_s = {{(ACC_W-DATA_W){bus.b_data[DATA_W-1]}}, bus.b_data} <<< FRAC_BITS;
        if (k_r == {IA{1'b0}}) begin
            acc_base_s = bias_shift_s;
        end else begin
            acc_base_s = acc_r;
        end
        mac_sum_s = acc_base_s + prod_ext_s;
    end

    nn_sat_act #(
        .ACC_W     (ACC_W),
        .DATA_W    (DATA_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_sat_act (
        .acc    (mac_sum_s),
        .result (act_s)
    );

    // Sequencing: IDLE -> (LOAD -> MAC x N_IN -> WRITE) x N_OUT -> DONE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.go) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: state_next_s = ST_MAC;
            ST_MAC: begin
                if (k_last_s) begin
                    state_next_s = ST_WRITE;
                end else begin
                    state_next_s = ST_MAC;
                end
            end
            ST_WRITE: begin
                if (j_last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Datapath and output registers; the result is captured on the last MAC
    // edge so out_we/out_data are presented during the WRITE cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            j_r        <= {OA{1'b0}};
            k_r        <= {IA{1'b0}};
            base_r     <= {WA{1'b0}};
            acc_r      <= {ACC_W{1'b0}};
            in_addr_r  <= {IA{1'b0}};
            w_addr_r   <= {WA{1'b0}};
            b_addr_r   <= {OA{1'b0}};
            out_addr_r <= {OA{1'b0}};
            out_data_r <= {DATA_W{1'b0}};
            out_we_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            busy_r   <= (state_next_s != ST_IDLE);
            done_r   <= (state_next_s == ST_DONE);
            out_we_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.go) begin
                        j_r       <= {OA{1'b0}};
                        base_r    <= {WA{1'b0}};
                        b_addr_r  <= {OA{1'b0}};
                        in_addr_r <= {IA{1'b0}};
                        w_addr_r  <= {WA{1'b0}};
                    end
                end
                ST_LOAD: begin
                    k_r <= {IA{1'b0}};
                    if (MULTI_IN) begin
                        in_addr_r <= in_addr_r + IA'(1);
                        w_addr_r  <= w_addr_r + WA'(1);
                    end
                end
                ST_MAC: begin
                    acc_r <= mac_sum_s;
                    k_r   <= k_r + IA'(1);
                    if (issue_s) begin
                        in_addr_r <= in_addr_r + IA'(1);
                        w_addr_r  <= w_addr_r + WA'(1);
                    end
                    if (k_last_s) begin
                        out_we_r   <= 1'b1;
                        out_addr_r <= j_r;
                        out_data_r <= act_s;
                    end
                end
                ST_WRITE: begin
                    base_r <= base_r + BASE_STEP;
                    if (!j_last_s) begin
                        j_r       <= j_r + OA'(1);
                        b_addr_r  <= j_r + OA'(1);
                        in_addr_r <= {IA{1'b0}};
                        w_addr_r  <= base_r + BASE_STEP;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.in_addr  = in_addr_r;
    assign bus.w_addr   = w_addr_r;
    assign bus.b_addr   = b_addr_r;
    assign bus.out_addr = out_addr_r;
    assign bus.out_data = out_data_r;
    assign bus.out_we   = out_we_r;

endmodule
